fetch_unit: RTL and testbench

Instruction-fetch controller for the 32-bit ARM pipeline. It sits between the PC register and the IF/ID boundary: it reads the current `pc` and drives the PC register's `pc_in` and `freeze` inputs. It also runs a req/ack handshake to a variable-latency instruction memory and owns the IF/ID pipeline register, with stall on hazard and flush on taken branch.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch controller for the 32-bit ARM pipeline. It drives the
// PC register (pc_in / pc_freeze) from the current pc. It runs a req/ack
// handshake to a variable-latency instruction memory and owns the IF/ID
// pipeline register, which stalls on hazard and flushes on a taken branch.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   pc            current PC from the PC register
//   branch_taken  taken branch resolved downstream (flush + redirect)
//   branch_addr   branch target, valid with branch_taken
//   hazard        ID-stage stall, holds IF/ID
//   imem_rdata    instruction word, valid with imem_ack
//   imem_ack      memory completes the outstanding request this cycle
//   pc_in         next PC to the PC register
//   pc_freeze     1 = PC register holds its value
//   imem_req      request to instruction memory
//   imem_addr     request address
//   if_id_pc      registered fetched address + 4
//   if_id_instr   registered instruction
//   if_id_valid   IF/ID holds a live instruction
module fetch_unit #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] pc,
   input  logic                  branch_taken,
   input  logic [WORD_WIDTH-1:0] branch_addr,
   input  logic                  hazard,
   input  logic [WORD_WIDTH-1:0] imem_rdata,
   input  logic                  imem_ack,
   output logic [WORD_WIDTH-1:0] pc_in,
   output logic                  pc_freeze,
   output logic                  imem_req,
   output logic [WORD_WIDTH-1:0] imem_addr,
   output logic [WORD_WIDTH-1:0] if_id_pc,
   output logic [WORD_WIDTH-1:0] if_id_instr,
   output logic                  if_id_valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [WORD_WIDTH-1:0] hold_instr;
   logic [WORD_WIDTH-1:0] hold_pc;
   logic [WORD_WIDTH-1:0] drop_addr;
   logic                  update;
   logic                  load_fetch;
   logic                  load_hold;
   logic                  capture;
   logic                  enter_drop;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. A taken branch always wins over an ack
   // or a hazard. Leaving FETCH on a branch without an ack orphans the
   // request: DROP keeps presenting the old address until the memory
   // answers, so the handshake stays consistent.
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      imem_addr  = pc;
      update     = 1'b0;
      load_fetch = 1'b0;
      load_hold  = 1'b0;
      capture    = 1'b0;
      enter_drop = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (branch_taken) begin
               update = 1'b1;
               if (!imem_ack) begin
                  state_next = DROP;
                  enter_drop = 1'b1;
               end
            end else if (imem_ack && !hazard) begin
               update     = 1'b1;
               load_fetch = 1'b1;
            end else if (imem_ack) begin
               state_next = HOLD;
               capture    = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               update     = 1'b1;
               state_next = FETCH;
            end else if (!hazard) begin
               update     = 1'b1;
               load_hold  = 1'b1;
               state_next = FETCH;
            end
         end
         DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr;
            if (branch_taken) begin
               update = 1'b1;
            end
            if (imem_ack) begin
               state_next = FETCH;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
      if (rst) begin
         imem_req = 1'b0;
      end
      pc_freeze = rst | ~update;
      pc_in     = branch_taken ? branch_addr : pc + WORD_WIDTH'(4);
   end

   // Hold buffer, orphaned-request address and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_instr  <= '0;
         hold_pc     <= '0;
         drop_addr   <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
      end else begin
         if (capture) begin
            hold_instr <= imem_rdata;
            hold_pc    <= pc;
         end
         if (enter_drop) begin
            drop_addr <= pc;
         end
         if (branch_taken) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
         end else if (hazard) begin
            if_id_valid <= if_id_valid;
         end else if (load_fetch) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc + WORD_WIDTH'(4);
         end else if (load_hold) begin
            if_id_valid <= 1'b1;
            if_id_instr <= hold_instr;
            if_id_pc    <= hold_pc + WORD_WIDTH'(4);
         end else begin
            // Nothing delivered this cycle: insert a bubble.
            if_id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. A local PC register closes the loop through
// pc_in/pc_freeze. Memory responses are driven directly from a table of
// per-cycle vectors. Combinational outputs are checked on the falling edge,
// and registered outputs plus the PC are checked just after the rising edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        hazard;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] pc_in;
   logic        pc_freeze;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        bt;
      logic [31:0] baddr;
      logic        hz;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_freeze;
      logic [31:0] exp_pc_in;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_ifpc;
      logic [31:0] exp_pc;
   } vec_t;

   localparam int NUM_VEC = 27;
   vec_t vecs [NUM_VEC];

   fetch_unit #(.WORD_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .hazard       (hazard),
      .imem_rdata   (imem_rdata),
      .imem_ack     (imem_ack),
      .pc_in        (pc_in),
      .pc_freeze    (pc_freeze),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register model driven by the unit under test.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= 32'h0;
      end else if (!pc_freeze) begin
         pc <= pc_in;
      end
   end

   function automatic vec_t mkVec(
      input logic bt, input logic [31:0] baddr, input logic hz,
      input logic ack, input logic [31:0] rdata,
      input logic req, input logic [31:0] addr, input logic frz,
      input logic [31:0] pcin, input logic val, input logic [31:0] instr,
      input logic [31:0] ifpc, input logic [31:0] pcnext);
      vec_t v;
      v.bt = bt;         v.baddr = baddr;    v.hz = hz;
      v.ack = ack;       v.rdata = rdata;
      v.exp_req = req;   v.exp_addr = addr;  v.exp_freeze = frz;
      v.exp_pc_in = pcin;
      v.exp_valid = val; v.exp_instr = instr; v.exp_ifpc = ifpc;
      v.exp_pc = pcnext;
      return v;
   endfunction

   task automatic checkOutput(input string what, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (step %0d): got %h expected %h", what, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      branch_taken = v.bt;
      branch_addr  = v.baddr;
      hazard       = v.hz;
      imem_ack     = v.ack;
      imem_rdata   = v.rdata;
      @(negedge clk);
      checkOutput("imem_req", idx, {31'b0, imem_req}, {31'b0, v.exp_req});
      if (v.exp_req) begin
         checkOutput("imem_addr", idx, imem_addr, v.exp_addr);
      end
      checkOutput("pc_freeze", idx, {31'b0, pc_freeze}, {31'b0, v.exp_freeze});
      checkOutput("pc_in", idx, pc_in, v.exp_pc_in);
      @(posedge clk);
      #1;
      checkOutput("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, v.exp_valid});
      checkOutput("if_id_instr", idx, if_id_instr, v.exp_instr);
      checkOutput("if_id_pc", idx, if_id_pc, v.exp_ifpc);
      checkOutput("pc", idx, pc, v.exp_pc);
   endtask

   initial begin
      vec_t v;
      // Zero-wait memory from pc 0.
      vecs[0]  = mkVec(0, 0, 0, 1, 32'hE000_0000, 1, 32'h0,  0, 32'h4,  1, 32'hE000_0000, 32'h4,  32'h4);
      vecs[1]  = mkVec(0, 0, 0, 1, 32'hE000_0004, 1, 32'h4,  0, 32'h8,  1, 32'hE000_0004, 32'h8,  32'h8);
      vecs[2]  = mkVec(0, 0, 0, 1, 32'hE000_0008, 1, 32'h8,  0, 32'hC,  1, 32'hE000_0008, 32'hC,  32'hC);
      // Three-cycle memory for 0xC.
      vecs[3]  = mkVec(0, 0, 0, 0, 32'h0,         1, 32'hC,  1, 32'h10, 0, 32'hE000_0008, 32'hC,  32'hC);
      vecs[4]  = mkVec(0, 0, 0, 0, 32'h0,         1, 32'hC,  1, 32'h10, 0, 32'hE000_0008, 32'hC,  32'hC);
      vecs[5]  = mkVec(0, 0, 0, 1, 32'hE000_000C, 1, 32'hC,  0, 32'h10, 1, 32'hE000_000C, 32'h10, 32'h10);
      // Ack under hazard, two hazard cycles, then release from HOLD.
      vecs[6]  = mkVec(0, 0, 1, 1, 32'hE000_0010, 1, 32'h10, 1, 32'h14, 1, 32'hE000_000C, 32'h10, 32'h10);
      vecs[7]  = mkVec(0, 0, 1, 0, 32'h0,         0, 32'h0,  1, 32'h14, 1, 32'hE000_000C, 32'h10, 32'h10);
      vecs[8]  = mkVec(0, 0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h14, 1, 32'hE000_0010, 32'h14, 32'h14);
      // Branch to 0x100 while 0x14 is outstanding: DROP until the late ack.
      vecs[9]  = mkVec(0, 0, 0, 0, 32'h0,         1, 32'h14, 1, 32'h18, 0, 32'hE000_0010, 32'h14, 32'h14);
      vecs[10] = mkVec(1, 32'h100, 0, 0, 32'h0,   1, 32'h14, 0, 32'h100, 0, 32'h0, 32'h0, 32'h100);
      vecs[11] = mkVec(0, 0, 0, 0, 32'h0,         1, 32'h14, 1, 32'h104, 0, 32'h0, 32'h0, 32'h100);
      vecs[12] = mkVec(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h14, 1, 32'h104, 0, 32'h0, 32'h0, 32'h100);
      vecs[13] = mkVec(0, 0, 0, 1, 32'hE000_0100, 1, 32'h100, 0, 32'h104, 1, 32'hE000_0100, 32'h104, 32'h104);
      // Branch together with hazard while IF/ID is valid: flush wins.
      vecs[14] = mkVec(1, 32'h200, 1, 0, 32'h0,   1, 32'h104, 0, 32'h200, 0, 32'h0, 32'h0, 32'h200);
      vecs[15] = mkVec(0, 0, 0, 1, 32'h1111_1111, 1, 32'h104, 1, 32'h204, 0, 32'h0, 32'h0, 32'h200);
      // Branch in the same cycle as an ack in FETCH discards the data.
      vecs[16] = mkVec(1, 32'h300, 0, 1, 32'hE000_0200, 1, 32'h200, 0, 32'h300, 0, 32'h0, 32'h0, 32'h300);
      vecs[17] = mkVec(0, 0, 0, 1, 32'hE000_0300, 1, 32'h300, 0, 32'h304, 1, 32'hE000_0300, 32'h304, 32'h304);
      // PC wrap at the top of the address space.
      vecs[18] = mkVec(1, 32'hFFFF_FFFC, 0, 1, 32'h2222_2222, 1, 32'h304, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
      vecs[19] = mkVec(0, 0, 0, 1, 32'hE000_0FFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hE000_0FFC, 32'h0, 32'h0);
      // Branch while in HOLD discards the buffer.
      vecs[20] = mkVec(0, 0, 1, 1, 32'hE000_0000, 1, 32'h0, 1, 32'h4, 1, 32'hE000_0FFC, 32'h0, 32'h0);
      vecs[21] = mkVec(1, 32'h40, 1, 0, 32'h0,    0, 32'h0, 0, 32'h40, 0, 32'h0, 32'h0, 32'h40);
      vecs[22] = mkVec(0, 0, 0, 1, 32'hE000_0040, 1, 32'h40, 0, 32'h44, 1, 32'hE000_0040, 32'h44, 32'h44);
      // Second branch while in DROP redirects but keeps the orphaned address.
      vecs[23] = mkVec(1, 32'h80, 0, 0, 32'h0,    1, 32'h44, 0, 32'h80, 0, 32'h0, 32'h0, 32'h80);
      vecs[24] = mkVec(1, 32'h90, 0, 0, 32'h0,    1, 32'h44, 0, 32'h90, 0, 32'h0, 32'h0, 32'h90);
      vecs[25] = mkVec(0, 0, 0, 1, 32'hBAD0_BAD0, 1, 32'h44, 1, 32'h94, 0, 32'h0, 32'h0, 32'h90);
      vecs[26] = mkVec(0, 0, 0, 1, 32'hE000_0090, 1, 32'h90, 0, 32'h94, 1, 32'hE000_0090, 32'h94, 32'h94);

      // Reset: combinational outputs forced, registers cleared.
      rst          = 1'b1;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      hazard       = 1'b0;
      imem_ack     = 1'b0;
      imem_rdata   = 32'h0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset imem_req", -1, {31'b0, imem_req}, 32'h0);
      checkOutput("reset pc_freeze", -1, {31'b0, pc_freeze}, 32'h1);
      @(posedge clk);
      #1;
      checkOutput("reset if_id_valid", -1, {31'b0, if_id_valid}, 32'h0);
      checkOutput("reset if_id_instr", -1, if_id_instr, 32'h0);
      checkOutput("reset if_id_pc", -1, if_id_pc, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Reset in the middle of a wait state, with a late ack during reset.
      v = mkVec(0, 0, 0, 0, 32'h0, 1, 32'h94, 1, 32'h98, 0, 32'hE000_0090, 32'h94, 32'h94);
      applyStimulus(v, 100);
      rst        = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("midreset imem_req", 101, {31'b0, imem_req}, 32'h0);
      checkOutput("midreset pc_freeze", 101, {31'b0, pc_freeze}, 32'h1);
      @(posedge clk);
      #1;
      checkOutput("midreset if_id_valid", 101, {31'b0, if_id_valid}, 32'h0);
      checkOutput("midreset if_id_instr", 101, if_id_instr, 32'h0);
      checkOutput("midreset if_id_pc", 101, if_id_pc, 32'h0);
      checkOutput("midreset pc", 101, pc, 32'h0);
      rst = 1'b0;
      v = mkVec(0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h4, 0, 32'h0, 32'h0, 32'h0);
      applyStimulus(v, 102);
      v = mkVec(0, 0, 0, 1, 32'hE000_0000, 1, 32'h0, 0, 32'h4, 1, 32'hE000_0000, 32'h4, 32'h4);
      applyStimulus(v, 103);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
